// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: one outstanding instruction-memory request, a single
// ID register with a one-entry hold buffer, and redirect-driven flush.
module fetch_decode_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [3:0]  id_opcode,
    output logic [3:0]  id_rd,
    output logic [3:0]  id_rs,
    output logic [3:0]  id_imm
);

    // state  | meaning
    // FETCH  | issue a request at pc (suppressed by redirect)
    // WAIT   | request outstanding, waiting for imem_valid
    // HOLD   | response parked in hold buffer while ID is stalled
    // DROP   | request outstanding but flushed; discard its response
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic        id_free;

    assign id_free = !id_valid_q || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_valid_d   = id_valid_q && stall;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (redirect) begin
            id_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            pc_d         = redirect_pc;
            case (state_q)
                S_FETCH: state_d = S_FETCH;
                S_HOLD:  state_d = S_FETCH;
                // A response arriving in the redirect cycle itself is dropped here,
                // otherwise the outstanding one is still owed and must be eaten.
                S_WAIT,
                S_DROP:  state_d = imem_valid ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        pc_d = pc_q + 16'd1;
                        if (id_free) begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc_d    = pc_q;
                            state_d    = S_FETCH;
                        end else begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_q;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && hold_valid_q) begin
                        id_valid_d   = 1'b1;
                        id_instr_d   = hold_instr_q;
                        id_pc_d      = hold_pc_q;
                        hold_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_valid)
                        state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 16'h0000;
            id_pc_q      <= 16'h0000;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 16'h0000;
            hold_pc_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) && !redirect && !rst;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[15:12];
    assign id_rd     = id_instr_q[11:8];
    assign id_rs     = id_instr_q[7:4];
    assign id_imm    = id_instr_q[3:0];

endmodule
